// File: rtl/shape_draw_sched_pkg.sv
// shape_pkg: descriptor layout, FSM states and widths shared by the shape draw scheduler.
package shape_pkg;
  localparam int CORDW = 16;
  localparam int CIDXW = 4;
  localparam int DESCW = 6 * CORDW + CIDXW;
  typedef struct packed {
    logic [CIDXW-1:0] cidx;
    logic signed [CORDW-1:0] x0;
    logic signed [CORDW-1:0] y0;
    logic signed [CORDW-1:0] x1;
    logic signed [CORDW-1:0] y1;
    logic signed [CORDW-1:0] x2;
    logic signed [CORDW-1:0] y2;
  } shape_desc_t;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAW, DONE} state_t;
endpackage

// File: rtl/shape_draw_sched_if.sv
// shape_draw_sched_if: shape ROM read port plus triangle draw engine control.
interface shape_draw_sched_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4,
  parameter int ADDRW = 4
);
  logic [ADDRW-1:0] rom_addr;
  logic [6*CORDW+CIDXW-1:0] rom_data;
  logic signed [CORDW-1:0] x0, y0, x1, y1, x2, y2;
  logic [CIDXW-1:0] cidx;
  logic draw_start;
  logic draw_oe;
  logic draw_done;
  modport master (
    output rom_addr, x0, y0, x1, y1, x2, y2, cidx, draw_start, draw_oe,
    input  rom_data, draw_done
  );
  modport slave (
    input  rom_addr, x0, y0, x1, y1, x2, y2, cidx, draw_start, draw_oe,
    output rom_data, draw_done
  );
endinterface

// File: rtl/shape_draw_sched_frame_pacer.sv
// frame_pacer: counts frames after a run starts and gates the draw engine output enable.
module frame_pacer #(
  parameter int DRAW_WAIT = 300,
  parameter int PACED = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic frame,
  output logic oe
);
  localparam int CW = DRAW_WAIT > 0 ? $clog2(DRAW_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT = CW'(DRAW_WAIT);
  logic [CW-1:0] cnt;
  logic oe_q;
  logic ready;
  assign ready = cnt == WAIT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      oe_q <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      oe_q <= 1'b0;
    end else begin
      if (enable && frame && !ready) cnt <= cnt + 1'b1;
      oe_q <= enable && ready && (PACED == 0 || frame);
    end
  // the register lags busy by a cycle, so gate it to drop oe as soon as the sequence ends
  assign oe = oe_q && enable;
endmodule

// File: rtl/shape_draw_sched.sv
// shape_draw_sched: walks the shape ROM table, loading and starting the draw engine once per entry.
module shape_draw_sched
  import shape_pkg::*;
#(
  parameter int CORDW = shape_pkg::CORDW,
  parameter int CIDXW = shape_pkg::CIDXW,
  parameter int SHAPE_CNT = 3,
  parameter int ADDRW = 4,
  parameter int DRAW_WAIT = 300,
  parameter int PACED = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic frame,
  shape_draw_sched_if.master bus,
  output logic busy,
  output logic done
);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(SHAPE_CNT - 1);
  state_t state;
  logic [ADDRW-1:0] idx;
  logic pending;
  logic accept;
  logic oe;
  logic [DESCW-1:0] raw;
  shape_desc_t desc;
  assign raw = bus.rom_data;
  assign desc = shape_desc_t'(raw);
  assign accept = state == IDLE && frame && (pending || run);
  assign bus.draw_oe = oe;
  frame_pacer #(.DRAW_WAIT(DRAW_WAIT), .PACED(PACED)) u_pacer (
    .clk(clk), .rst_n(rst_n), .enable(busy), .clear(accept), .frame(frame), .oe(oe)
  );
  // rom_addr moves with idx so the synchronous ROM has its data ready by LATCH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bus.rom_addr <= '0;
      bus.draw_start <= 1'b0;
      bus.cidx <= '0;
      bus.x0 <= '0;
      bus.y0 <= '0;
      bus.x1 <= '0;
      bus.y1 <= '0;
      bus.x2 <= '0;
      bus.y2 <= '0;
    end else begin
      bus.draw_start <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            state <= FETCH;
            idx <= '0;
            bus.rom_addr <= '0;
            busy <= 1'b1;
            pending <= 1'b0;
          end else if (run) pending <= 1'b1;
        FETCH: begin
          bus.rom_addr <= idx;
          state <= LATCH;
        end
        LATCH: begin
          bus.cidx <= desc.cidx;
          bus.x0 <= desc.x0;
          bus.y0 <= desc.y0;
          bus.x1 <= desc.x1;
          bus.y1 <= desc.y1;
          bus.x2 <= desc.x2;
          bus.y2 <= desc.y2;
          bus.draw_start <= 1'b1;
          state <= DRAW;
        end
        DRAW:
          if (bus.draw_done) begin
            if (idx == LAST) state <= DONE;
            else begin
              idx <= idx + 1'b1;
              bus.rom_addr <= idx + 1'b1;
              state <= FETCH;
            end
          end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shape_draw_sched.sv
// tb_shape_draw_sched: directed checks of sequencing and frame pacing on a free-running and a paced instance.
module tb_shape_draw_sched;
  import shape_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic frame = 1'b0;
  logic draw_done = 1'b0;
  logic busy0, done0, busy1, done1;
  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_start = 0;
  int n_oe1 = 0;
  int lat;
  shape_desc_t rom [0:15];
  shape_draw_sched_if #(.CORDW(16), .CIDXW(4), .ADDRW(4)) b0 ();
  shape_draw_sched_if #(.CORDW(16), .CIDXW(4), .ADDRW(4)) b1 ();
  shape_draw_sched #(.CORDW(16), .CIDXW(4), .SHAPE_CNT(3), .ADDRW(4), .DRAW_WAIT(0), .PACED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .run(run), .frame(frame), .bus(b0), .busy(busy0), .done(done0)
  );
  shape_draw_sched #(.CORDW(16), .CIDXW(4), .SHAPE_CNT(3), .ADDRW(4), .DRAW_WAIT(3), .PACED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run), .frame(frame), .bus(b1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  assign b0.draw_done = draw_done;
  assign b1.draw_done = draw_done;
  always @(posedge clk) begin
    b0.rom_data <= rom[b0.rom_addr];
    b1.rom_data <= rom[b1.rom_addr];
  end
  function automatic shape_desc_t mk(input int c, input int a, input int b, input int d,
                                     input int e, input int f, input int g);
    shape_desc_t s;
    s.cidx = 4'(c);
    s.x0 = 16'(a);
    s.y0 = 16'(b);
    s.x1 = 16'(d);
    s.y1 = 16'(e);
    s.x2 = 16'(f);
    s.y2 = 16'(g);
    return s;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (done0) n_done++;
    if (b0.draw_start) n_start++;
    if (b1.draw_oe) n_oe1++;
  endtask
  task automatic wait_start(output int l);
    l = 0;
    do begin
      step();
      l++;
    end while (!b0.draw_start && l < 40);
    if (!b0.draw_start) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: no draw_start within %0d cycles", l);
    end
  endtask
  task automatic pulse_done(input int n);
    repeat (n) step();
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
  endtask
  task automatic finish_rest(input int remaining);
    int l;
    for (int i = 0; i < remaining; i++) begin
      pulse_done(2);
      if (i < remaining - 1) wait_start(l);
    end
    repeat (4) step();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, b0.draw_start, b0.draw_oe, busy1, b1.draw_oe} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy0, done0, b0.draw_start, b0.draw_oe, busy1, b1.draw_oe});
    end
    checks++;
    if (b0.rom_addr !== 4'd0 || b0.x0 !== 16'sd0 || b0.y2 !== 16'sd0 || b0.cidx !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: addr=%0d x0=%0d y2=%0d cidx=%0d want all 0", b0.rom_addr, b0.x0, b0.y2, b0.cidx);
    end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_sequence();
    n_done = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (2) step();
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL pending_no_frame: busy=%b want 0", busy0);
    end
    frame = 1'b1;
    step();
    frame = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_accept: busy=%b want 1", busy0);
    end
    wait_start(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL start_latency0: got %0d want 2", lat);
    end
    checks++;
    if (b0.x0 !== 16'sd20 || b0.y0 !== 16'sd60 || b0.x1 !== 16'sd60 || b0.y2 !== 16'sd90 || b0.cidx !== 4'd2) begin
      errors++;
      $display("FAIL shape0: x0=%0d y0=%0d x1=%0d y2=%0d cidx=%0d want 20 60 60 90 2", b0.x0, b0.y0, b0.x1, b0.y2, b0.cidx);
    end
    checks++;
    if (b0.draw_oe !== 1'b1 || b1.draw_oe !== 1'b0 || b1.draw_start !== 1'b1) begin
      errors++;
      $display("FAIL oe_start: oe0=%b oe1=%b start1=%b want 1 0 1", b0.draw_oe, b1.draw_oe, b1.draw_start);
    end
    step();
    checks++;
    if (b0.draw_start !== 1'b0) begin
      errors++;
      $display("FAIL start_width: draw_start=%b want 0", b0.draw_start);
    end
    pulse_done(8);
    checks++;
    if (b0.rom_addr !== 4'd1) begin
      errors++;
      $display("FAIL addr_advance: rom_addr=%0d want 1", b0.rom_addr);
    end
    wait_start(lat);
    checks++;
    if (lat !== 2 || b0.cidx !== 4'hC || b0.x1 !== 16'sd150) begin
      errors++;
      $display("FAIL shape1: lat=%0d cidx=%0h x1=%0d want 2 c 150", lat, b0.cidx, b0.x1);
    end
    pulse_done(9);
    wait_start(lat);
    checks++;
    if (b0.cidx !== 4'd9 || b0.x0 !== -16'sd5 || b0.y1 !== 16'sd7) begin
      errors++;
      $display("FAIL shape2: cidx=%0d x0=%0d y1=%0d want 9 -5 7", b0.cidx, b0.x0, b0.y1);
    end
    pulse_done(9);
    repeat (5) step();
    checks++;
    if (n_done !== 1 || busy0 !== 1'b0 || b0.draw_oe !== 1'b0) begin
      errors++;
      $display("FAIL seq_end: done_pulses=%0d busy=%b oe=%b want 1 0 0", n_done, busy0, b0.draw_oe);
    end
  endtask
  task automatic test_run_ignored();
    n_done = 0;
    n_start = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    frame = 1'b1;
    step();
    frame = 1'b0;
    wait_start(lat);
    pulse_done(3);
    wait_start(lat);
    run = 1'b1;
    step();
    run = 1'b0;
    pulse_done(3);
    wait_start(lat);
    checks++;
    if (b0.rom_addr !== 4'd2 || b0.cidx !== 4'd9) begin
      errors++;
      $display("FAIL run_busy_index: rom_addr=%0d cidx=%0d want 2 9", b0.rom_addr, b0.cidx);
    end
    pulse_done(3);
    repeat (4) step();
    frame = 1'b1;
    step();
    frame = 1'b0;
    repeat (5) step();
    checks++;
    if (n_start !== 3 || n_done !== 1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL run_busy_ignored: starts=%0d dones=%0d busy=%b want 3 1 0", n_start, n_done, busy0);
    end
  endtask
  task automatic test_run_with_frame();
    run = 1'b1;
    frame = 1'b1;
    step();
    run = 1'b0;
    frame = 1'b0;
    wait_start(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL run_with_frame: latency=%0d want 2", lat);
    end
    finish_rest(3);
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (4) step();
    frame = 1'b1;
    step();
    frame = 1'b0;
    wait_start(lat);
    checks++;
    if (lat !== 2 || b0.cidx !== 4'd2) begin
      errors++;
      $display("FAIL run_early: latency=%0d cidx=%0d want 2 2", lat, b0.cidx);
    end
    finish_rest(3);
  endtask
  task automatic test_paced();
    run = 1'b1;
    frame = 1'b1;
    step();
    run = 1'b0;
    frame = 1'b0;
    wait_start(lat);
    n_oe1 = 0;
    for (int f = 0; f < 3; f++) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
      repeat (3) step();
    end
    checks++;
    if (n_oe1 !== 0 || b0.draw_oe !== 1'b1) begin
      errors++;
      $display("FAIL paced_wait: oe1_cycles=%0d oe0=%b want 0 1", n_oe1, b0.draw_oe);
    end
    frame = 1'b1;
    step();
    frame = 1'b0;
    checks++;
    if (b1.draw_oe !== 1'b1) begin
      errors++;
      $display("FAIL paced_frame4: oe=%b want 1", b1.draw_oe);
    end
    step();
    checks++;
    if (b1.draw_oe !== 1'b0 || n_oe1 !== 1) begin
      errors++;
      $display("FAIL paced_width: oe=%b cycles=%0d want 0 1", b1.draw_oe, n_oe1);
    end
    repeat (2) step();
    frame = 1'b1;
    step();
    frame = 1'b0;
    checks++;
    if (b1.draw_oe !== 1'b1) begin
      errors++;
      $display("FAIL paced_frame5: oe=%b want 1", b1.draw_oe);
    end
    step();
  endtask
  task automatic test_done_with_frame();
    draw_done = 1'b1;
    frame = 1'b1;
    step();
    draw_done = 1'b0;
    frame = 1'b0;
    checks++;
    if (b1.rom_addr !== 4'd1 || b1.draw_oe !== 1'b1) begin
      errors++;
      $display("FAIL done_with_frame: rom_addr=%0d oe=%b want 1 1", b1.rom_addr, b1.draw_oe);
    end
    wait_start(lat);
    finish_rest(2);
    checks++;
    if (busy1 !== 1'b0 || b1.draw_oe !== 1'b0) begin
      errors++;
      $display("FAIL paced_end: busy=%b oe=%b want 0 0", busy1, b1.draw_oe);
    end
  endtask
  task automatic test_reset_mid();
    run = 1'b1;
    frame = 1'b1;
    step();
    run = 1'b0;
    frame = 1'b0;
    wait_start(lat);
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, b0.draw_oe, b0.draw_start, busy1} !== 4'b0 || b0.x0 !== 16'sd0 || b0.cidx !== 4'd0 || b0.rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b oe=%b x0=%0d cidx=%0d addr=%0d want all 0", busy0, b0.draw_oe, b0.x0, b0.cidx, b0.rom_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_start = 0;
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    repeat (6) step();
    checks++;
    if (n_start !== 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: starts=%0d busy=%b want 0 0", n_start, busy0);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0] = mk(2, 20, 60, 60, 180, 110, 90);
    rom[1] = mk(12, 100, 10, 150, 70, 40, 30);
    rom[2] = mk(9, -5, 0, 3, 7, 8, 1);
    test_reset();
    test_sequence();
    test_run_ignored();
    test_run_with_frame();
    test_paced();
    test_done_with_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
